// File: rtl/cpri_lane_align_pkg.sv
// rtl/cpri_lane_align_pkg.sv - shared types and constants for the CPRI lane deskew stage
package cpri_align_pkg;

  localparam int SLOT_W = 7;
  localparam int SYMB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } align_state_t;

  // Header part of a FIFO entry; the full entry is {hdr, addr, data}
  typedef struct packed {
    logic              last;
    logic [SLOT_W-1:0] slot;
    logic [SYMB_W-1:0] symb;
  } lane_hdr_t;

  localparam int HDR_W = $bits(lane_hdr_t);

endpackage

// File: rtl/cpri_lane_align_fifo.sv
// rtl/cpri_lane_align_fifo.sv - per-lane show-ahead FIFO with full/empty/count
module cpri_lane_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd_en;
  logic          wr_en;

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage array carries no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/cpri_lane_align.sv
// rtl/cpri_lane_align.sv - multi-lane CPRI IQ deskew with header check, timeout and overflow
module cpri_lane_align
  import cpri_align_pkg::*;
#(
  parameter int LANE  = 8,
  parameter int DW    = 128,
  parameter int AW    = 11,
  parameter int DEPTH = 64,
  parameter int TMO   = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [LANE-1:0]               i_lane_en,
  input  logic [LANE-1:0][DW-1:0]       i_iq_data,
  input  logic [LANE-1:0][AW-1:0]       i_iq_addr,
  input  logic [LANE-1:0]               i_iq_vld,
  input  logic [LANE-1:0]               i_iq_last,
  input  logic [LANE-1:0][SLOT_W-1:0]   i_slot_idx,
  input  logic [LANE-1:0][SYMB_W-1:0]   i_symb_idx,
  output logic [LANE-1:0][DW-1:0]       o_iq_data,
  output logic [LANE-1:0][AW-1:0]       o_iq_addr,
  output logic                          o_iq_vld,
  output logic                          o_iq_last,
  output logic [SLOT_W-1:0]             o_slot_idx,
  output logic [SYMB_W-1:0]             o_symb_idx,
  output logic [LANE-1:0]               o_ovf,
  output logic                          o_mis_err,
  output logic                          o_tmo_err
);

  localparam int EW = HDR_W + AW + DW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TMO);

  align_state_t                 state;
  logic [LANE-1:0]              en_q;
  logic [LANE-1:0]              done_q;
  logic [TW-1:0]                tmo_cnt;

  logic [LANE-1:0]              push;
  logic [LANE-1:0]              pop;
  logic [LANE-1:0]              full;
  logic [LANE-1:0]              empty;
  logic [LANE-1:0]              lane_rdy;
  logic [LANE-1:0][CW-1:0]      lane_cnt;
  logic [LANE-1:0][EW-1:0]      head;

  logic [LANE-1:0]              h_last;
  logic [LANE-1:0][SLOT_W-1:0]  h_slot;
  logic [LANE-1:0][SYMB_W-1:0]  h_symb;
  logic [LANE-1:0][AW-1:0]      h_addr;
  logic [LANE-1:0][DW-1:0]      h_data;

  logic [SLOT_W-1:0]            ref_slot;
  logic [SYMB_W-1:0]            ref_symb;
  logic                         ref_found;
  logic                         hdr_eq;
  logic                         all_rdy;
  logic                         stream_pop;
  logic [LANE-1:0]              flush_pop;
  logic [LANE-1:0]              pop_last;
  logic                         all_last;
  logic                         any_last;
  logic                         tmo_hit;
  logic [LANE-1:0]              done_nxt;

  for (genvar g = 0; g < LANE; g++) begin : g_lane
    lane_hdr_t in_hdr;
    lane_hdr_t out_hdr;

    assign in_hdr  = '{last: i_iq_last[g], slot: i_slot_idx[g], symb: i_symb_idx[g]};
    assign push[g] = i_iq_vld[g] & en_q[g];

    cpri_lane_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_reset),
      .push  (push[g]),
      .din   ({in_hdr, i_iq_addr[g], i_iq_data[g]}),
      .pop   (pop[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (lane_cnt[g])
    );

    assign {out_hdr, h_addr[g], h_data[g]} = head[g];
    assign h_last[g]   = out_hdr.last;
    assign h_slot[g]   = out_hdr.slot;
    assign h_symb[g]   = out_hdr.symb;
    assign lane_rdy[g] = (lane_cnt[g] != '0);
  end

  // Reference header from the lowest enabled lane; check all enabled heads against it
  always_comb begin
    ref_slot  = '0;
    ref_symb  = '0;
    ref_found = 1'b0;
    hdr_eq    = 1'b1;
    for (int l = 0; l < LANE; l++) begin
      if (en_q[l] && !ref_found) begin
        ref_slot  = h_slot[l];
        ref_symb  = h_symb[l];
        ref_found = 1'b1;
      end
    end
    for (int l = 0; l < LANE; l++) begin
      if (en_q[l] && ((h_slot[l] != ref_slot) || (h_symb[l] != ref_symb))) begin
        hdr_eq = 1'b0;
      end
    end
  end

  // Pop control: lock-step in ALIGN/STREAM, independent per-lane drain in FLUSH.
  // ALIGN pops the first beat in the same cycle its headers check out, so a
  // packet starts two cycles after it lands in the FIFOs.
  always_comb begin
    all_rdy    = ((lane_rdy & en_q) == en_q);
    stream_pop = ((state == ALIGN) && all_rdy && hdr_eq) ||
                 ((state == STREAM) && all_rdy);
    flush_pop  = (state == FLUSH) ? (en_q & ~done_q & ~empty) : '0;
    pop        = stream_pop ? en_q : flush_pop;
    pop_last   = h_last & en_q;
    all_last   = (pop_last == en_q);
    any_last   = |pop_last;
    tmo_hit    = (tmo_cnt == TW'(TMO - 1));
    done_nxt   = done_q | (flush_pop & h_last);
  end

  // Sequencer with registered outputs, error pulses and sticky overflow
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      en_q       <= '0;
      done_q     <= '0;
      tmo_cnt    <= '0;
      o_iq_data  <= '0;
      o_iq_addr  <= '0;
      o_iq_vld   <= 1'b0;
      o_iq_last  <= 1'b0;
      o_slot_idx <= '0;
      o_symb_idx <= '0;
      o_ovf      <= '0;
      o_mis_err  <= 1'b0;
      o_tmo_err  <= 1'b0;
    end else begin
      o_iq_vld  <= 1'b0;
      o_mis_err <= 1'b0;
      o_tmo_err <= 1'b0;
      o_ovf     <= o_ovf | (push & full & ~pop);

      if (stream_pop) begin
        for (int l = 0; l < LANE; l++) begin
          o_iq_data[l] <= en_q[l] ? h_data[l] : '0;
          o_iq_addr[l] <= en_q[l] ? h_addr[l] : '0;
        end
        o_iq_vld   <= 1'b1;
        o_iq_last  <= all_last;
        o_slot_idx <= ref_slot;
        o_symb_idx <= ref_symb;
      end

      case (state)
        IDLE: begin
          en_q    <= i_lane_en;
          done_q  <= '0;
          tmo_cnt <= '0;
          if ((en_q != '0) && ((~empty & en_q) != '0)) begin
            state <= ALIGN;
          end
        end

        ALIGN, STREAM: begin
          if (stream_pop) begin
            tmo_cnt <= '0;
            if (all_last) begin
              state <= IDLE;
            end else if (any_last) begin
              o_mis_err <= 1'b1;
              done_q    <= ~en_q | pop_last;
              state     <= FLUSH;
            end else begin
              state <= STREAM;
            end
          end else if ((state == ALIGN) && all_rdy) begin
            // Heads present but headers disagree
            o_mis_err <= 1'b1;
            done_q    <= ~en_q;
            tmo_cnt   <= '0;
            state     <= FLUSH;
          end else if (tmo_hit) begin
            // Lanes that never delivered are treated as finished so the flush can end
            o_tmo_err <= 1'b1;
            done_q    <= ~en_q | empty;
            tmo_cnt   <= '0;
            state     <= FLUSH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        FLUSH: begin
          done_q  <= done_nxt;
          tmo_cnt <= '0;
          if (&done_nxt) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpri_lane_align.sv
// tb/tb_cpri_lane_align.sv - randomized directed bench for cpri_lane_align
module tb_cpri_lane_align;
  import cpri_align_pkg::*;

  localparam int LANE  = 8;
  localparam int DW    = 128;
  localparam int AW    = 11;
  localparam int DEPTH = 64;
  localparam int TMO   = 1024;
  localparam int MAXB  = 160;

  logic                         i_clk = 1'b0;
  logic                         i_reset;
  logic [LANE-1:0]              i_lane_en;
  logic [LANE-1:0][DW-1:0]      i_iq_data;
  logic [LANE-1:0][AW-1:0]      i_iq_addr;
  logic [LANE-1:0]              i_iq_vld;
  logic [LANE-1:0]              i_iq_last;
  logic [LANE-1:0][SLOT_W-1:0]  i_slot_idx;
  logic [LANE-1:0][SYMB_W-1:0]  i_symb_idx;
  logic [LANE-1:0][DW-1:0]      o_iq_data;
  logic [LANE-1:0][AW-1:0]      o_iq_addr;
  logic                         o_iq_vld;
  logic                         o_iq_last;
  logic [SLOT_W-1:0]            o_slot_idx;
  logic [SYMB_W-1:0]            o_symb_idx;
  logic [LANE-1:0]              o_ovf;
  logic                         o_mis_err;
  logic                         o_tmo_err;

  always #5 i_clk = ~i_clk;

  cpri_lane_align #(
    .LANE(LANE), .DW(DW), .AW(AW), .DEPTH(DEPTH), .TMO(TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_lane_en  (i_lane_en),
    .i_iq_data  (i_iq_data),
    .i_iq_addr  (i_iq_addr),
    .i_iq_vld   (i_iq_vld),
    .i_iq_last  (i_iq_last),
    .i_slot_idx (i_slot_idx),
    .i_symb_idx (i_symb_idx),
    .o_iq_data  (o_iq_data),
    .o_iq_addr  (o_iq_addr),
    .o_iq_vld   (o_iq_vld),
    .o_iq_last  (o_iq_last),
    .o_slot_idx (o_slot_idx),
    .o_symb_idx (o_symb_idx),
    .o_ovf      (o_ovf),
    .o_mis_err  (o_mis_err),
    .o_tmo_err  (o_tmo_err)
  );

  typedef struct packed {
    logic [LANE-1:0][DW-1:0] data;
    logic [LANE-1:0][AW-1:0] addr;
    logic                    last;
    logic [SLOT_W-1:0]       slot;
    logic [SYMB_W-1:0]       symb;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int mis_cnt = 0, tmo_cnt = 0, both_cnt = 0;
  int exp_mis = 0, exp_tmo = 0;
  int first_vld = -1, last_vld = -1, tmo_cyc = -1, push_edge = 0;

  int                p_len  [LANE];
  int                p_off  [LANE];
  logic [SLOT_W-1:0] p_slot [LANE];
  logic [SYMB_W-1:0] p_symb [LANE];
  logic [LANE-1:0]   p_act;
  logic [LANE-1:0]   cur_en;
  logic [LANE-1:0]   exp_ovf;
  logic [DW-1:0]     tx_data [LANE][MAXB];
  logic [AW-1:0]     tx_addr [LANE][MAXB];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor
  always @(negedge i_clk) begin
    if (i_reset) begin
      if (o_iq_vld) begin
        obs_q.push_back('{data: o_iq_data, addr: o_iq_addr, last: o_iq_last,
                          slot: o_slot_idx, symb: o_symb_idx});
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
      end
      if (o_mis_err) mis_cnt++;
      if (o_tmo_err) begin tmo_cnt++; tmo_cyc = cyc; end
      if (o_mis_err && o_tmo_err) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " vld"},  o_iq_vld, 0);
    chk({tag, " data"}, |o_iq_data, 0);
    chk({tag, " addr"}, |o_iq_addr, 0);
    chk({tag, " last"}, o_iq_last, 0);
    chk({tag, " slot"}, o_slot_idx, 0);
    chk({tag, " symb"}, o_symb_idx, 0);
    chk({tag, " ovf"},  o_ovf, 0);
    chk({tag, " mis"},  o_mis_err, 0);
    chk({tag, " tmo"},  o_tmo_err, 0);
  endtask

  task automatic set_all(input int len, input logic [SLOT_W-1:0] s, input logic [SYMB_W-1:0] y);
    for (int l = 0; l < LANE; l++) begin
      p_len[l] = len; p_off[l] = 0; p_slot[l] = s; p_symb[l] = y;
    end
    p_act = '1;
  endtask

  task automatic set_en(input logic [LANE-1:0] en);
    @(negedge i_clk);
    i_lane_en = en;
    cur_en    = en;
    repeat (3) @(negedge i_clk);
  endtask

  // Model: a packet is released only if every enabled lane delivers it with a
  // common header; a missing lane times out, a header disagreement is a mismatch.
  task automatic run_pkt(input bit model, input int stop_after, input int drain);
    int tmax, rl, b;
    bit miss, diff;
    beat_t e;
    tmax = 0; rl = -1; miss = 0; diff = 0;
    for (int l = 0; l < LANE; l++) begin
      for (int k = 0; k < p_len[l]; k++) begin
        tx_data[l][k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        tx_addr[l][k] = AW'($urandom());
      end
      if (p_act[l] && (p_off[l] + p_len[l] > tmax)) tmax = p_off[l] + p_len[l];
      if (cur_en[l]) begin
        if (!p_act[l]) miss = 1;
        else if (rl < 0) rl = l;
        else if ((p_slot[l] != p_slot[rl]) || (p_symb[l] != p_symb[rl])) diff = 1;
      end
    end
    if (model) begin
      if (miss) exp_tmo++;
      else if (diff) exp_mis++;
      else begin
        for (int k = 0; k < p_len[rl]; k++) begin
          e = '0;
          for (int l = 0; l < LANE; l++) begin
            if (cur_en[l]) begin
              e.data[l] = tx_data[l][k];
              e.addr[l] = tx_addr[l][k];
            end
          end
          e.last = (k == p_len[rl] - 1);
          e.slot = p_slot[rl];
          e.symb = p_symb[rl];
          exp_q.push_back(e);
        end
      end
    end
    first_vld = -1;
    for (int t = 0; t < tmax; t++) begin
      @(negedge i_clk);
      if (t == 0) push_edge = cyc + 1;
      for (int l = 0; l < LANE; l++) begin
        b = t - p_off[l];
        if (p_act[l] && (b >= 0) && (b < p_len[l])) begin
          i_iq_vld[l]   = 1'b1;
          i_iq_data[l]  = tx_data[l][b];
          i_iq_addr[l]  = tx_addr[l][b];
          i_iq_last[l]  = (b == p_len[l] - 1);
          i_slot_idx[l] = p_slot[l];
          i_symb_idx[l] = p_symb[l];
        end else begin
          i_iq_vld[l]  = 1'b0;
          i_iq_last[l] = 1'b0;
        end
      end
      if ((stop_after > 0) && (t + 1 >= stop_after)) break;
    end
    if (stop_after == 0) begin
      @(negedge i_clk);
      i_iq_vld  = '0;
      i_iq_last = '0;
    end
    repeat (drain) @(negedge i_clk);
  endtask

  task automatic compare_beats(input string tag);
    int n;
    chk({tag, " beat count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < LANE; l++) begin
        chk($sformatf("%s beat%0d lane%0d data", tag, i, l), obs_q[i].data[l], exp_q[i].data[l]);
      end
      chk($sformatf("%s beat%0d addr/last/slot/symb", tag, i),
          {obs_q[i].addr, obs_q[i].last, obs_q[i].slot, obs_q[i].symb},
          {exp_q[i].addr, exp_q[i].last, exp_q[i].slot, exp_q[i].symb});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, " mis pulses"}, mis_cnt, exp_mis);
    chk({tag, " tmo pulses"}, tmo_cnt, exp_tmo);
    chk({tag, " mis+tmo together"}, both_cnt, 0);
  endtask

  initial begin
    i_reset = 1'b0; i_lane_en = '0; i_iq_data = '0; i_iq_addr = '0;
    i_iq_vld = '0; i_iq_last = '0; i_slot_idx = '0; i_symb_idx = '0;
    cur_en = '0;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_reset = 1'b1;
    set_en(8'hFF);

    // All lanes aligned, 132 beats, slot 5 symb 3
    set_all(132, 7'd5, 4'd3);
    run_pkt(1, 0, 20);
    chk("aligned first vld cycle", first_vld, push_edge + 2);
    chk("aligned contiguous span", last_vld - first_vld, 131);
    compare_beats("aligned");
    chk_errs("aligned");

    // Lane 3 skewed by 20 cycles
    set_all(50, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 13)));
    p_off[3] = 20;
    run_pkt(1, 0, 40);
    chk("skew starts after late lane", first_vld > push_edge + 20, 1);
    chk("skew contiguous span", last_vld - first_vld, 49);
    compare_beats("skew");
    chk_errs("skew");

    // Half mask, upper lanes idle
    set_en(8'h0F);
    set_all(30, 7'd77, 4'd9);
    p_act = 8'h0F;
    run_pkt(1, 0, 20);
    compare_beats("mask0F");
    chk_errs("mask0F");

    // Header mismatch on lane 2, then a clean packet
    set_en(8'hFF);
    set_all(40, 7'd12, 4'd3);
    p_symb[2] = 4'd4;
    run_pkt(1, 0, 30);
    compare_beats("mismatch");
    chk_errs("mismatch");
    set_all(25, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 13)));
    run_pkt(1, 0, 20);
    compare_beats("after mismatch");
    chk_errs("after mismatch");

    // Lane 6 silent: timeout TMO cycles after ALIGN entry, then recovery
    set_all(40, 7'd33, 4'd1);
    p_act[6] = 1'b0;
    run_pkt(1, 0, TMO + 100);
    chk("timeout pulse cycle", tmo_cyc, push_edge + 1 + TMO);
    compare_beats("timeout");
    chk_errs("timeout");
    set_all(20, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 13)));
    run_pkt(1, 0, 20);
    compare_beats("after timeout");
    chk_errs("after timeout");

    // Overflow: lane 0 gets more than DEPTH beats while lane 1 never arrives
    set_en(8'h03);
    set_all(70, 7'd1, 4'd2);
    p_act = 8'h01;
    exp_ovf = '0;
    for (int l = 0; l < LANE; l++) begin
      if (cur_en[l] && p_act[l] && (p_len[l] > DEPTH)) exp_ovf[l] = 1'b1;
    end
    run_pkt(0, 0, 5);
    chk("overflow flag", o_ovf, exp_ovf);
    repeat (50) @(negedge i_clk);
    chk("overflow flag sticky", o_ovf, exp_ovf);
    chk("overflow no output", obs_q.size(), 0);
    chk_errs("overflow");
    i_reset = 1'b0;
    #1;
    chk_zero("reset after overflow");
    obs_q.delete();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_iq_vld = '0;
    i_iq_last = '0;

    // Asynchronous reset in the middle of a streaming packet
    set_en(8'hFF);
    set_all(100, 7'd99, 4'd7);
    p_off[3] = 10;
    run_pkt(0, 40, 0);
    @(negedge i_clk);
    chk("mid-stream vld before reset", o_iq_vld, 1);
    i_reset = 1'b0;
    #1;
    chk_zero("mid-stream reset");
    obs_q.delete();
    i_iq_vld = '0;
    i_iq_last = '0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    set_en(8'hFF);
    repeat (20) @(negedge i_clk);
    compare_beats("post reset idle");

    set_all(10, 7'($urandom_range(0, 127)), 4'($urandom_range(0, 13)));
    run_pkt(1, 0, 20);
    compare_beats("post reset packet");
    chk_errs("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
